// File: rtl/coriolis_fpmul_arbiter_if.sv
// Requester-side bus of the shared FP multiplier arbiter.
//   ivalid/iready/in_a/in_b : operand handshake, one lane per requester,
//                             lane i packed at [i*STREAMW +: STREAMW]
//   ovalid/oready/out1      : result handshake, ovalid one-hot, shared out1
// master = requester side, slave = arbiter side.
interface coriolis_fpmul_arbiter_if #(
    parameter int NREQ    = 2,
    parameter int STREAMW = 34
);
    logic [NREQ-1:0]         ivalid;
    logic [NREQ-1:0]         iready;
    logic [NREQ*STREAMW-1:0] in_a;
    logic [NREQ*STREAMW-1:0] in_b;
    logic [NREQ-1:0]         ovalid;
    logic [NREQ-1:0]         oready;
    logic [STREAMW-1:0]      out1;

    modport master (
        output ivalid, in_a, in_b, oready,
        input  iready, ovalid, out1
    );

    modport slave (
        input  ivalid, in_a, in_b, oready,
        output iready, ovalid, out1
    );
endinterface

// File: rtl/coriolis_fpmul_arbiter.sv
// Round-robin arbiter sharing one pipelined flopoco FP multiplier among NREQ
// requesters. Granted operands are registered onto mul_x/mul_y, and an owner
// tag travels alongside the multiplier pipeline so each result is steered
// back to its requester. The owner's back-pressure freezes everything.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : requester handshake (slave modport of coriolis_fpmul_arbiter_if)
//   mul_x/y    : registered operands to the external multiplier
//   mul_stall  : freezes the external multiplier pipeline
//   mul_r      : multiplier result, forwarded on bus.out1
//   inflight   : number of valid tags in the tag pipeline
module coriolis_fpmul_arbiter #(
    parameter int                 STREAMW    = 34,
    parameter int                 NREQ       = 2,
    parameter int                 LAT        = 3,
    parameter bit                 CONST_Y_EN = 1'b0,
    parameter logic [STREAMW-1:0] CONST_Y    = {2'b01, 32'h43d80000}
) (
    input  logic                        clk,
    input  logic                        rst,
    coriolis_fpmul_arbiter_if.slave     bus,
    output logic [STREAMW-1:0]          mul_x,
    output logic [STREAMW-1:0]          mul_y,
    output logic                        mul_stall,
    input  logic [STREAMW-1:0]          mul_r,
    output logic [$clog2(LAT+2)-1:0]    inflight
);
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW   = IDW + 1;
    localparam int CNTW = $clog2(LAT + 2);

    // Tag pipeline: stage 0 sits beside mul_x/mul_y, stage LAT beside mul_r.
    logic [LAT:0]     tag_vld_q, tag_vld_d;
    logic [IDW-1:0]   tag_id_q [LAT+1];
    logic [IDW-1:0]   tag_id_d [LAT+1];
    logic [IDW-1:0]   p_q, p_d;
    logic [STREAMW-1:0] mul_x_q, mul_x_d, mul_y_q, mul_y_d;
    logic [CNTW-1:0]  inflight_q, inflight_d;

    logic [NREQ-1:0]  req_rot;
    logic             gnt_found;
    logic [IDW-1:0]   gnt_id;
    logic [SW-1:0]    gnt_sum;
    logic [STREAMW-1:0] x_sel, y_sel;
    logic             consume, advance, accept;

    // Rotate requests so bit k is requester (p+k) mod NREQ; the first set
    // bit is the round-robin winner.
    // NOTE: every variable written in always_comb gets a default at the top,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        req_rot   = NREQ'({bus.ivalid, bus.ivalid} >> p_q);
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_rot[k]) begin
                gnt_found = 1'b1;
                gnt_sum   = {1'b0, p_q} + SW'(k);
                gnt_id    = (gnt_sum >= SW'(NREQ)) ? IDW'(gnt_sum - SW'(NREQ))
                                                   : IDW'(gnt_sum);
            end
        end
    end

    // Only the owner's ready matters; an empty result stage never stalls.
    assign consume   = |(bus.ovalid & bus.oready);
    assign advance   = ~tag_vld_q[LAT] | consume;
    assign accept    = advance & gnt_found;
    assign mul_stall = ~advance;
    assign bus.out1  = mul_r;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign inflight  = inflight_q;

    always_comb begin
        bus.iready = '0;
        bus.ovalid = '0;
        x_sel      = '0;
        y_sel      = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.iready[i] = accept && (gnt_id == IDW'(i));
            bus.ovalid[i] = tag_vld_q[LAT] && (tag_id_q[LAT] == IDW'(i));
            if (gnt_id == IDW'(i)) begin
                x_sel = bus.in_a[i*STREAMW +: STREAMW];
                y_sel = bus.in_b[i*STREAMW +: STREAMW];
            end
        end
        if (CONST_Y_EN) y_sel = CONST_Y;
    end

    always_comb begin
        tag_vld_d  = tag_vld_q;
        tag_id_d   = tag_id_q;
        p_d        = p_q;
        mul_x_d    = mul_x_q;
        mul_y_d    = mul_y_q;
        inflight_d = inflight_q;

        // Bubbles shift along with real tags; nothing is compacted.
        if (advance) begin
            tag_vld_d   = {tag_vld_q[LAT-1:0], accept};
            tag_id_d[0] = gnt_id;
            for (int s = 1; s <= LAT; s++) tag_id_d[s] = tag_id_q[s-1];
        end

        if (accept) begin
            mul_x_d = x_sel;
            mul_y_d = y_sel;
            p_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end

        // A simultaneous accept and consume leaves the count unchanged.
        case ({accept, consume})
            2'b10:   inflight_d = inflight_q + CNTW'(1);
            2'b01:   inflight_d = inflight_q - CNTW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value, regardless of the order of statements.
    // NOTE: the owner-id array is reset along with the valids so the pipeline
    // comes out of reset fully defined, not just logically empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q  <= '0;
            for (int s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
            p_q        <= '0;
            mul_x_q    <= '0;
            mul_y_q    <= '0;
            inflight_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            p_q        <= p_d;
            mul_x_q    <= mul_x_d;
            mul_y_q    <= mul_y_d;
            inflight_q <= inflight_d;
        end
    end
endmodule
